// File: rtl/spad_pkg.sv
// Shared state encoding and default timing for the SPAD quench sequencer.
package spad_pkg;

   typedef enum logic [3:0] {
      S_IDLE    = 4'b0001,
      S_QUENCH  = 4'b0010,
      S_RESET   = 4'b0100,
      S_HOLDOFF = 4'b1000
   } state_t;

   localparam int I_IDLE    = 0;
   localparam int I_QUENCH  = 1;
   localparam int I_RESET   = 2;
   localparam int I_HOLDOFF = 3;

   localparam int DEF_QUENCH_CYC  = 5;
   localparam int DEF_RESET_CYC   = 5;
   localparam int DEF_HOLDOFF_CYC = 10;
   localparam int DEF_WINDOW_CYC  = 50000;
   localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/spad_gate_counter.sv
// Gate window timer with saturating photon accumulator and latched result.
module spad_gate_counter
   import spad_pkg::*;
#(
   parameter int WINDOW_CYC = DEF_WINDOW_CYC,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             accept,
   output logic [CNT_W-1:0] photon_cnt,
   output logic             cnt_valid,
   output logic             cnt_ovf
);

   localparam logic [15:0]      LAST = 16'(WINDOW_CYC - 1);
   localparam logic [CNT_W-1:0] MAX  = '1;
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [15:0]      wt;
   logic [CNT_W-1:0] acc;
   logic [CNT_W-1:0] acc_nx;
   logic             sat;
   logic             sat_nx;
   logic             wrap;

   // an accept landing on the wrap cycle belongs to the closing window
   always_comb begin
      acc_nx = acc;
      sat_nx = sat;
      if (accept) begin
         if (acc == MAX) sat_nx = 1'b1;
         else            acc_nx = acc + ONE;
      end
   end

   assign wrap = (wt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wt         <= '0;
         acc        <= '0;
         sat        <= 1'b0;
         photon_cnt <= '0;
         cnt_valid  <= 1'b0;
         cnt_ovf    <= 1'b0;
      end else begin
         cnt_valid <= 1'b0;
         if (!enable) begin
            wt  <= '0;
            acc <= '0;
            sat <= 1'b0;
         end else if (wrap) begin
            wt         <= '0;
            photon_cnt <= acc_nx;
            cnt_ovf    <= sat_nx;
            cnt_valid  <= 1'b1;
            acc        <= '0;
            sat        <= 1'b0;
         end else begin
            wt  <= wt + 16'd1;
            acc <= acc_nx;
            sat <= sat_nx;
         end
      end
   end

endmodule

// File: rtl/spad_quench_ctrl.sv
// Event-driven SPAD quench/reset sequencer with gated photon counting.
module spad_quench_ctrl
   import spad_pkg::*;
#(
   parameter int QUENCH_CYC  = DEF_QUENCH_CYC,
   parameter int RESET_CYC   = DEF_RESET_CYC,
   parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
   parameter int WINDOW_CYC  = DEF_WINDOW_CYC,
   parameter int CNT_W       = DEF_CNT_W,
   parameter bit RST_PIN_EN  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             aval_in,
   output logic             quench_en_n,
   output logic             quench_pwm,
   output logic             rst_en,
   output logic             rst_pwm,
   output logic             busy,
   output logic [CNT_W-1:0] photon_cnt,
   output logic             cnt_valid,
   output logic             cnt_ovf
);

   localparam logic [7:0] Q_LD = 8'(QUENCH_CYC - 1);
   localparam logic [7:0] R_LD = 8'(RESET_CYC - 1);
   localparam logic [7:0] H_LD =
      (HOLDOFF_CYC == 0) ? 8'd0 : 8'(HOLDOFF_CYC - 1);

   logic   s1, s2, s3;
   logic   det;
   logic   accept;
   state_t state, state_nx;
   logic [7:0] tmr, tmr_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= aval_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign det = s2 & ~s3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         tmr         <= '0;
         quench_en_n <= 1'b1;
         rst_en      <= 1'b0;
      end else begin
         state       <= state_nx;
         tmr         <= tmr_nx;
         quench_en_n <= ~enable;
         rst_en      <= enable & RST_PIN_EN;
      end
   end

   always_comb begin
      state_nx = state;
      tmr_nx   = tmr;
      accept   = 1'b0;
      unique case (1'b1)
         state[I_IDLE]: begin
            if (enable && det) begin
               state_nx = S_QUENCH;
               tmr_nx   = Q_LD;
               accept   = 1'b1;
            end
         end
         state[I_QUENCH]: begin
            if (tmr == 8'd0) begin
               state_nx = S_RESET;
               tmr_nx   = R_LD;
            end else tmr_nx = tmr - 8'd1;
         end
         state[I_RESET]: begin
            if (tmr == 8'd0) begin
               state_nx = (HOLDOFF_CYC == 0) ? S_IDLE : S_HOLDOFF;
               tmr_nx   = H_LD;
            end else tmr_nx = tmr - 8'd1;
         end
         state[I_HOLDOFF]: begin
            if (tmr == 8'd0) state_nx = S_IDLE;
            else             tmr_nx   = tmr - 8'd1;
         end
         default: begin
            state_nx = S_IDLE;
            tmr_nx   = '0;
         end
      endcase
   end

   // outputs come straight off the one-hot state flops
   assign quench_pwm = state[I_QUENCH];
   assign rst_pwm    = state[I_RESET] & RST_PIN_EN;
   assign busy       = ~state[I_IDLE];

   spad_gate_counter #(
      .WINDOW_CYC (WINDOW_CYC),
      .CNT_W      (CNT_W)
   ) u_gate (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .accept     (accept),
      .photon_cnt (photon_cnt),
      .cnt_valid  (cnt_valid),
      .cnt_ovf    (cnt_ovf)
   );

endmodule

// File: tb/tb_spad_quench_ctrl.sv
// Directed bench: pulse timing, dead time, gate window, saturation, enable/reset.
module tb_spad_quench_ctrl;
   import spad_pkg::*;

   typedef struct {
      logic [15:0] cnt;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, enable, aval0, aval2;

   logic qen0, q0, ren0, r0, b0, v0, o0;
   logic qen1, q1, ren1, r1, b1, v1, o1;
   logic qen2, q2, ren2, r2, b2, v2, o2;
   logic [15:0] pc0, pc1;
   logic [1:0]  pc2;

   int vectors = 0;
   int errors  = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;

   int st0[10] = '{0, 25, 50, 110, 118, 197, 310, 340, 380, 480};
   int st2[6]  = '{0, 6, 12, 18, 24, 130};

   always #10 clk = ~clk;

   spad_quench_ctrl #(.WINDOW_CYC(100)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .aval_in(aval0),
      .quench_en_n(qen0), .quench_pwm(q0), .rst_en(ren0),
      .rst_pwm(r0), .busy(b0), .photon_cnt(pc0),
      .cnt_valid(v0), .cnt_ovf(o0));

   spad_quench_ctrl #(.WINDOW_CYC(100), .RST_PIN_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .aval_in(aval0),
      .quench_en_n(qen1), .quench_pwm(q1), .rst_en(ren1),
      .rst_pwm(r1), .busy(b1), .photon_cnt(pc1),
      .cnt_valid(v1), .cnt_ovf(o1));

   spad_quench_ctrl #(
      .QUENCH_CYC(1), .RESET_CYC(1), .HOLDOFF_CYC(0),
      .WINDOW_CYC(100), .CNT_W(2)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .aval_in(aval2),
      .quench_en_n(qen2), .quench_pwm(q2), .rst_en(ren2),
      .rst_pwm(r2), .busy(b2), .photon_cnt(pc2),
      .cnt_valid(v2), .cnt_ovf(o2));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic hi0(int c);
      for (int i = 0; i < 10; i++)
         if (c >= st0[i] && c < st0[i] + 3) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic hi2(int c);
      for (int i = 0; i < 6; i++)
         if (c >= st2[i] && c < st2[i] + 2) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      aval0  = 1'b0;
      aval2  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_qen", qen0, 1);
      chk("rst_q", q0, 0);
      chk("rst_r", r1, 0);
      chk("rst_ren", ren1, 0);
      chk("rst_busy", b0, 0);
      chk("rst_cnt", pc0, 0);
      chk("rst_valid", v0, 0);
      chk("rst_ovf", o0, 0);
      rst_n = 1'b1;

      // iteration c drives inputs seen by edge c; outputs show edge c-1
      for (int c = 0; c < 500; c++) begin
         logic strobe;
         @(negedge clk);
         if (c == 1) begin
            chk("qen_on", qen0, 0);
            chk("ren_on", ren1, 1);
            chk("ren_pin_off", ren0, 0);
         end
         if (c >= 1 && c <= 24) begin
            chk("q_pulse", q0, (c >= 3 && c <= 7));
            chk("r_off", r0, 0);
            chk("r_pulse", r1, (c >= 8 && c <= 12));
            chk("busy_seq", b0, (c >= 3 && c <= 22));
         end
         if (c > 0) chk("excl", q1 & r1, 0);
         if (c >= 301 && c <= 369) begin
            chk("q_drop", q0, (c >= 313 && c <= 317));
            chk("busy_drop", b0, (c >= 313 && c <= 332));
         end
         if (c >= 315 && c <= 370) chk("qen_off", qen0, 1);

         strobe = (c == 100 || c == 200 || c == 300 || c == 470);
         if (c > 0) begin
            chk("valid0", v0, strobe);
            chk("valid1", v1, strobe);
            chk("valid2", v2, strobe);
         end
         if (v0) begin
            if (qa.size() == 0) chk("qa_extra", 1, 0);
            else begin
               ea = qa.pop_front();
               chk("cnt0", pc0, ea.cnt);
               chk("ovf0", o0, ea.ovf);
               chk("cnt1", pc1, ea.cnt);
               chk("ovf1", o1, ea.ovf);
            end
         end
         if (v2) begin
            if (qb.size() == 0) chk("qb_extra", 1, 0);
            else begin
               eb = qb.pop_front();
               chk("cnt2", pc2, eb.cnt);
               chk("ovf2", o2, eb.ovf);
            end
         end

         if (c == 489) begin
            chk("r_before_rst", r1, 1);
            rst_n = 1'b0;
            #1;
            chk("arst_r", r1, 0);
            chk("arst_q", q1, 0);
            chk("arst_busy", b1, 0);
            chk("arst_cnt", pc0, 0);
            chk("arst_qen", qen0, 1);
            chk("arst_ren", ren1, 0);
         end
         if (c == 492) rst_n = 1'b1;

         enable = (c < 314) || (c >= 370);
         aval0  = hi0(c);
         aval2  = hi2(c);
         if (c == 0) begin
            qa.push_back('{cnt: 16'd3, ovf: 1'b0});
            qb.push_back('{cnt: 16'd3, ovf: 1'b1});
         end
         if (c == 100) begin
            qa.push_back('{cnt: 16'd2, ovf: 1'b0});
            qb.push_back('{cnt: 16'd1, ovf: 1'b0});
         end
         if (c == 200) begin
            qa.push_back('{cnt: 16'd0, ovf: 1'b0});
            qb.push_back('{cnt: 16'd0, ovf: 1'b0});
         end
         if (c == 370) begin
            qa.push_back('{cnt: 16'd1, ovf: 1'b0});
            qb.push_back('{cnt: 16'd0, ovf: 1'b0});
         end
      end

      chk("qa_left", qa.size(), 0);
      chk("qb_left", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/spad_quench_ctrl.md
Name: spad_quench_ctrl

Overview:
Active quench/reset sequencer for the SPAD front end in the photon-detector CPLD, running at 50 MHz. It consumes the avalanche comparator output, drives the quench/reset pins, and replaces the free-running 1 MHz PWM source with event-driven pulses. It also counts accepted photons over a fixed gate window and presents a latched count to the LED/readout logic downstream.

Parameters:
QUENCH_CYC, 5, quench pulse length in clk cycles (1..255)
RESET_CYC, 5, reset pulse length in clk cycles (1..255)
HOLDOFF_CYC, 10, dead time after reset before re-arming (0..255; 0 = no holdoff state)
WINDOW_CYC, 50000, gate window length in clk cycles (1 ms at 50 MHz, 2..65535)
CNT_W, 16, photon counter width
RST_PIN_EN, 0, 1 = drive rst_pwm/rst_en; 0 = hold both low (board rev A rst_pwm net shorted to GND)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous, active-low reset
enable  in  1  arm detector; synchronous level
aval_in  in  1  asynchronous avalanche comparator output, active high
quench_en_n  out  1  quench driver enable, active low
quench_pwm  out  1  quench pulse
rst_en  out  1  reset driver enable
rst_pwm  out  1  reset pulse
busy  out  1  high in QUENCH/RESET/HOLDOFF
photon_cnt  out  CNT_W  count latched at last window end
cnt_valid  out  1  one-cycle strobe when photon_cnt updates
cnt_ovf  out  1  latched window saturated
Behaviour:
- Reset values: FSM=IDLE, all outputs 0 except quench_en_n=1. photon_cnt=0, cnt_valid=0, cnt_ovf=0. Sync flops, timers and accumulator are 0.
- aval_in passes through a 2-flop synchronizer (s1, s2) plus a delayed copy s3. det = s2 & ~s3, i.e. rising edge only; a held-high input yields one detection.
- FSM, one-hot, registered outputs decoded from state:
  - IDLE: if enable & det, go to QUENCH, load timer with QUENCH_CYC-1, accept the photon.
  - QUENCH: quench_pwm=1. At timer==0 go to RESET, load RESET_CYC-1.
  - RESET: rst_pwm=1 only if RST_PIN_EN. At timer==0 go to HOLDOFF (load HOLDOFF_CYC-1), or to IDLE if HOLDOFF_CYC==0.
  - HOLDOFF: no pulses. At timer==0 go to IDLE.
- Latency: aval_in high at edge k sets s1 at k, s2 at k+1. The FSM enters QUENCH and quench_pwm rises at edge k+2.
- Pulse widths: quench_pwm is high exactly QUENCH_CYC cycles. rst_pwm follows in the very next cycle for exactly RESET_CYC cycles. quench_pwm and rst_pwm are never high together.
- Detections outside IDLE are ignored: not counted, no retrigger.
- enable deasserted mid-sequence: the sequence completes normally, then the FSM stays in IDLE.
- quench_en_n = ~enable, registered. rst_en = enable & RST_PIN_EN, registered.
- Gate window:
  - The window timer runs only while enable=1. It counts 0..WINDOW_CYC-1, then wraps.
  - On the wrap cycle, photon_cnt <= acc (including an accept in that same cycle), cnt_ovf <= sat flag, cnt_valid=1 for one cycle. acc and sat then clear.
  - enable=0 clears the window timer, acc and sat. photon_cnt is held.
- Accumulator saturates at 2^CNT_W-1; a further accept sets sat.
- Timers are 8 bits. The window timer is 16 bits. There is no wrap-around beyond the parameter bounds.
- rst_n asserted mid-sequence: all pulses drop immediately (asynchronous reset) and the FSM returns to IDLE.

Decomposition:
- Package spad_pkg holds:
  - the FSM state encoding (IDLE, QUENCH, RESET, HOLDOFF as one-hot constants);
  - the default timing constants (QUENCH_CYC, RESET_CYC, HOLDOFF_CYC, WINDOW_CYC) so the top level and bench share them.
- One sub-module: spad_gate_counter, containing the window timer, saturating accumulator, latch/strobe and ovf flag. Its inputs are enable and an accept pulse.
- Synchronizer and FSM stay in spad_quench_ctrl.

Test Plan:
- Single pulse: enable=1, aval_in high for 3 cycles at edge k -> quench_pwm high edges k+2..k+6 (5 cycles). rst_pwm low throughout (RST_PIN_EN=0). busy low at k+22. With RST_PIN_EN=1 -> rst_pwm high k+7..k+11.
- Dead time: second aval_in edge 8 cycles after the first -> no retrigger, count increments by 1 only. Edge 25 cycles after -> second quench, count +2.
- Window: WINDOW_CYC=100, 3 separated pulses in the window -> cnt_valid strobe at cycle 100 with photon_cnt=3, next window starts at 0. Pulse accepted on the wrap cycle -> counted in the closing window.
- Saturation: CNT_W=2, 5 pulses in one window -> photon_cnt=3, cnt_ovf=1. Next window with 1 pulse -> photon_cnt=1, cnt_ovf=0.
- Enable/reset: drop enable during QUENCH -> sequence finishes, quench_en_n=1, no new triggers, acc cleared. Assert rst_n during RESET -> all pulses 0 immediately, photon_cnt=0.
